// File: rtl/microcode_dispatcher.sv
// Opcode queue feeding a microcode unit; issues one segment at a time and forwards its control
// words. Optional stream timeout fault is enabled by defining MC_DISPATCH_TIMEOUT_EN.
module microcode_dispatcher #(
    parameter int unsigned OPCODE_W = 11,
    parameter int unsigned CTRL_W   = 32,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mc_sos,
    output logic [OPCODE_W-1:0] mc_opcode,
    input  logic [CTRL_W-1:0]   mc_ctrl,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic                ctrl_valid,
    output logic                seg_done,
    output logic [7:0]          seg_words,
    output logic                busy,
    output logic                fault
);

    localparam int unsigned PtrW = $clog2(QDEPTH);

    typedef enum logic [2:0] {
        StIdle, StIssue, StLat1, StLat2, StStream, StDrain1, StDrain2, StFault
    } state_e;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] mem_q [QDEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                push, pop;

    logic                mc_sos_q, mc_sos_d;
    logic [OPCODE_W-1:0] mc_opcode_q, mc_opcode_d;
    logic [CTRL_W-1:0]   ctrl_out_q, ctrl_out_d;
    logic                ctrl_valid_q, ctrl_valid_d;
    logic                seg_done_q, seg_done_d;
    logic [7:0]          seg_words_q, seg_words_d;
    logic [7:0]          cnt_q, cnt_d, cnt_inc;

    assign in_ready = (count_q != (PtrW + 1)'(QDEPTH));
    assign push     = in_valid && in_ready;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_opcode;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef MC_DISPATCH_TIMEOUT_EN
    logic fault_q, fault_d;
    assign fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign fault          = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        mc_sos_d     = 1'b0;
        mc_opcode_d  = mc_opcode_q;
        ctrl_out_d   = ctrl_out_q;
        ctrl_valid_d = 1'b0;
        seg_done_d   = 1'b0;
        seg_words_d  = seg_words_q;
        cnt_d        = cnt_q;
`ifdef MC_DISPATCH_TIMEOUT_EN
        fault_d      = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    mc_opcode_d = mem_q[rd_ptr_q];
                    mc_sos_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: state_d = StLat1;
            StLat1:  state_d = StLat2;
            StLat2:  state_d = StStream;
            StStream: begin
                ctrl_out_d   = mc_ctrl;
                ctrl_valid_d = 1'b1;
                cnt_d        = cnt_inc;
                if (mc_ctrl[0]) begin
                    seg_words_d = cnt_inc;
                    seg_done_d  = 1'b1;
                    state_d     = StDrain1;
                end
`ifdef MC_DISPATCH_TIMEOUT_EN
                else if (cnt_inc == 8'(TIMEOUT)) begin
                    fault_d     = 1'b1;
                    seg_done_d  = 1'b1;
                    seg_words_d = 8'(TIMEOUT);
                    state_d     = StFault;
                end
`endif
            end
            StDrain1: state_d = StDrain2;
            StDrain2: state_d = StIdle;
            StFault: begin
`ifdef MC_DISPATCH_TIMEOUT_EN
                state_d = StFault;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mc_sos_q     <= 1'b0;
            mc_opcode_q  <= '0;
            ctrl_out_q   <= '0;
            ctrl_valid_q <= 1'b0;
            seg_done_q   <= 1'b0;
            seg_words_q  <= '0;
            cnt_q        <= '0;
`ifdef MC_DISPATCH_TIMEOUT_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mc_sos_q     <= mc_sos_d;
            mc_opcode_q  <= mc_opcode_d;
            ctrl_out_q   <= ctrl_out_d;
            ctrl_valid_q <= ctrl_valid_d;
            seg_done_q   <= seg_done_d;
            seg_words_q  <= seg_words_d;
            cnt_q        <= cnt_d;
`ifdef MC_DISPATCH_TIMEOUT_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign mc_sos     = mc_sos_q;
    assign mc_opcode  = mc_opcode_q;
    assign ctrl_out   = ctrl_out_q;
    assign ctrl_valid = ctrl_valid_q;
    assign seg_done   = seg_done_q;
    assign seg_words  = seg_words_q;
    assign busy       = !((state_q == StIdle) && (count_q == '0));

endmodule

// File: tb/tb_microcode_dispatcher.sv
// Bench for microcode_dispatcher: timeline-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with periodic resets.
module tb_microcode_dispatcher;

    localparam int QD = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] in_opcode = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mc_sos;
    logic [10:0] mc_opcode;
    logic [31:0] mc_ctrl = '0;
    logic [31:0] ctrl_out;
    logic        ctrl_valid, seg_done, busy, fault;
    logic [7:0]  seg_words;

    microcode_dispatcher #(
        .OPCODE_W(11), .CTRL_W(32), .QDEPTH(QD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_opcode(in_opcode), .in_valid(in_valid),
        .in_ready(in_ready), .mc_sos(mc_sos), .mc_opcode(mc_opcode), .mc_ctrl(mc_ctrl),
        .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .seg_done(seg_done),
        .seg_words(seg_words), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: segment timeline in absolute edge numbers. A pop at edge E issues in the
    // following cycle, words are sampled from edge E+4, and the next pop may happen 3 edges after
    // the eos edge.
    logic [10:0] mq[$];
    int          edge_n = 0, pop_ok_at = 0, stream_from = 0, m_cnt = 0;
    bit          seg_active = 0, m_fault = 0, model_ok = 0, do_push;
    logic        e_sos = 0, e_valid = 0, e_done = 0;
    logic [10:0] e_op = '0;
    logic [31:0] e_ctrl = '0;
    logic [7:0]  e_words = '0;

    always @(posedge clk) begin
        cyc++;
        edge_n++;
        e_sos = 0; e_valid = 0; e_done = 0;
        if (!rst_n) begin
            model_ok = 1; mq.delete(); seg_active = 0; m_fault = 0; pop_ok_at = 0; m_cnt = 0;
            e_op = '0; e_ctrl = '0; e_words = '0;
        end else begin
            do_push = in_valid && (mq.size() != QD);
            if (!seg_active && !m_fault && edge_n >= pop_ok_at && mq.size() > 0) begin
                e_op = mq.pop_front(); e_sos = 1; seg_active = 1;
                stream_from = edge_n + 4; m_cnt = 0;
            end else if (seg_active && edge_n >= stream_from) begin
                e_ctrl = mc_ctrl; e_valid = 1;
                if (m_cnt < 255) m_cnt++;
                if (mc_ctrl[0]) begin
                    e_words = 8'(m_cnt); e_done = 1; seg_active = 0; pop_ok_at = edge_n + 3;
                end
`ifdef MC_DISPATCH_TIMEOUT_EN
                else if (m_cnt == TO) begin
                    m_fault = 1; e_done = 1; e_words = 8'(TO); seg_active = 0;
                end
`endif
            end
            if (do_push) mq.push_back(in_opcode);
        end
    end

    int          sos_cnt = 0, done_cnt = 0;
    logic [10:0] sos_log[$];
    int          sos_cyc[$];

    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", 64'(in_ready), 64'(mq.size() != QD));
            chk("mc_sos", 64'(mc_sos), 64'(e_sos));
            chk("mc_opcode", 64'(mc_opcode), 64'(e_op));
            chk("ctrl_valid", 64'(ctrl_valid), 64'(e_valid));
            if (e_valid) chk("ctrl_out", 64'(ctrl_out), 64'(e_ctrl));
            chk("seg_done", 64'(seg_done), 64'(e_done));
            chk("seg_words", 64'(seg_words), 64'(e_words));
            chk("busy", 64'(busy),
                64'(seg_active || m_fault || (edge_n < pop_ok_at - 1) || mq.size() != 0));
            chk("fault", 64'(fault), 64'(m_fault));
            if (mc_sos) begin
                sos_cnt++;
                sos_log.push_back(mc_opcode);
                sos_cyc.push_back(cyc);
            end
            if (seg_done) done_cnt++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [10:0] op);
        int n = 0;
        in_valid = 1'b1;
        in_opcode = op;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_sos();
        int n = 0;
        while (!mc_sos && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("sos_seen", 64'(mc_sos), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("went_idle", 64'(busy), 64'd0);
    endtask

    int          base_sos, base_done, sz;
    logic [31:0] r;
    logic [10:0] exp_order[6];

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);

        // Three-word segment for opcode 0x005.
        base_sos = sos_cnt; base_done = done_cnt;
        mc_ctrl = 32'h0;
        push(11'h005);
        wait_sos();
        chk("d1_opcode", 64'(mc_opcode), 64'h005);
        repeat (3) @(negedge clk);
        mc_ctrl = 32'h10;
        @(negedge clk);
        chk("d1_w1_valid", 64'(ctrl_valid), 64'd1);
        chk("d1_w1", 64'(ctrl_out), 64'h10);
        mc_ctrl = 32'h20;
        @(negedge clk);
        chk("d1_w2", 64'(ctrl_out), 64'h20);
        mc_ctrl = 32'h31;
        @(negedge clk);
        chk("d1_w3", 64'(ctrl_out), 64'h31);
        chk("d1_done", 64'(seg_done), 64'd1);
        chk("d1_words", 64'(seg_words), 64'd3);
        mc_ctrl = 32'h0;
        repeat (10) @(negedge clk);
        chk("d1_sos_count", 64'(sos_cnt - base_sos), 64'd1);
        chk("d1_done_count", 64'(done_cnt - base_done), 64'd1);

        // Two queued one-word segments: issue spacing 7 cycles.
        mc_ctrl = 32'h1;
        base_sos = sos_cnt;
        push(11'h011);
        push(11'h022);
        for (int i = 0; i < 100 && sos_cnt < base_sos + 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        sz = sos_cyc.size();
        chk("d2_two_sos", 64'(sos_cnt - base_sos), 64'd2);
        if (sz >= 2) chk("d2_spacing", 64'(sos_cyc[sz-1] - sos_cyc[sz-2]), 64'd7);
        wait_idle();

        // Fill the queue while a segment streams; the fifth waits for the first pop.
        mc_ctrl = 32'h0;
        push(11'h100);
        wait_sos();
        for (int i = 0; i < 4; i++) push(11'(12'h201 + i));
        chk("d3_full_not_ready", 64'(in_ready), 64'd0);
        mc_ctrl = 32'h1;
        push(11'h205);
        wait_idle();
        repeat (2) @(negedge clk);
        exp_order = '{11'h100, 11'h201, 11'h202, 11'h203, 11'h204, 11'h205};
        sz = sos_log.size();
        for (int i = 0; i < 6; i++)
            if (sz >= 6) chk("d3_order", 64'(sos_log[sz-6+i]), 64'(exp_order[i]));

        // Reset in the middle of a stream.
        mc_ctrl = 32'h0;
        push(11'h0AA);
        push(11'h0BB);
        wait_sos();
        repeat (8) @(negedge clk);
        chk("d4_streaming", 64'(ctrl_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("d4_sos", 64'(mc_sos), 64'd0);
        chk("d4_opcode", 64'(mc_opcode), 64'd0);
        chk("d4_ctrl_out", 64'(ctrl_out), 64'd0);
        chk("d4_valid", 64'(ctrl_valid), 64'd0);
        chk("d4_words", 64'(seg_words), 64'd0);
        chk("d4_busy", 64'(busy), 64'd0);
        chk("d4_ready", 64'(in_ready), 64'd1);
        base_sos = sos_cnt;
        repeat (20) @(negedge clk);
        chk("d4_no_sos", 64'(sos_cnt - base_sos), 64'd0);

        // Segment with no eos.
        do_reset();
        mc_ctrl = 32'h0;
        base_sos = sos_cnt; base_done = done_cnt;
        push(11'h0CC);
        wait_sos();
        push(11'h0DD);
        repeat (10) @(negedge clk);
`ifdef MC_DISPATCH_TIMEOUT_EN
        chk("d5_fault", 64'(fault), 64'd1);
        chk("d5_words", 64'(seg_words), 64'd8);
        chk("d5_done", 64'(seg_done), 64'd1);
`else
        chk("d5_no_fault", 64'(fault), 64'd0);
        chk("d5_no_done", 64'(seg_done), 64'd0);
`endif
        repeat (30) @(negedge clk);
        chk("d5_one_sos", 64'(sos_cnt - base_sos), 64'd1);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst_n = (i % 400 < 398);
            in_valid = 1'($urandom_range(0, 1));
            in_opcode = 11'($urandom);
            r = $urandom;
            r[0] = ($urandom_range(0, 2) == 0);
            mc_ctrl = r;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
